// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative radix-2 multiply/divide unit for the EX stage.
// It owns the HI/LO registers and decodes the R-type funct field itself.
// MULT/MULTU use shift-add and DIV/DIVU use restoring division. Both work on
// operand magnitudes, one bit per cycle. A FIX cycle then applies the signs.
//
// Ports:
//   clk    rising-edge clock
//   reset  asynchronous, active-low reset
//   start  request, sampled only while not busy
//   funct  R-type funct of the request
//   a, b   rs / rt operands (WIDTH bits)
//   busy   operation in flight (MUL, DIV or FIX)
//   done   one-cycle pulse; hi/lo hold the new result in this cycle
//   hi, lo HI / LO architectural registers
module muldiv_unit #(
  parameter int WIDTH = 64
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [5:0]       funct,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int W    = WIDTH;
  localparam int SH32 = W - 32;  // aligns a 32-bit operand with the top of the iteration register

  typedef enum logic [2:0] {S_IDLE, S_MUL, S_DIV, S_FIX, S_DONE} state_t;

  state_t state, state_nxt;

  logic [2*W-1:0] acc;    // product of the magnitudes
  logic [W-1:0]   opx;    // multiplier bits (MUL), or dividend shifting into quotient (DIV)
  logic [W-1:0]   opy;    // multiplicand / divisor magnitude
  logic [W-1:0]   rem;    // partial remainder
  logic [6:0]     cnt;
  logic           is_d, is_div, neg_q, neg_r, div_zero;

  function automatic logic [W-1:0] sext32(input logic [31:0] x);
    logic [W-1:0] r;
    r       = {W{x[31]}};
    r[31:0] = x;
    return r;
  endfunction

  function automatic logic [W-1:0] zext32(input logic [31:0] x);
    logic [W-1:0] r;
    r       = '0;
    r[31:0] = x;
    return r;
  endfunction

  // ---------------- decode and operand formation ----------------
  logic         f_d, f_sgn, f_div, is_md, is_mthi, is_mtlo, can_accept, go;
  logic         neg_a, neg_b;
  logic [W-1:0] op_a, op_b, mag_a, mag_b, opx_init;

  // NOTE: every signal driven in an always_comb gets a default first. Then no
  // path through the block can leave a signal unassigned, so no latch is inferred.
  always_comb begin
    f_d     = funct[2];
    f_sgn   = ~funct[0];
    f_div   = funct[1];
    is_md   = (funct[5:3] == 3'b011) && (!funct[2] || W == 64);
    is_mthi = (funct == 6'b010001);
    is_mtlo = (funct == 6'b010011);

    if (f_d) begin
      op_a = a;
      op_b = b;
    end else begin
      op_a = f_sgn ? sext32(a[31:0]) : zext32(a[31:0]);
      op_b = f_sgn ? sext32(b[31:0]) : zext32(b[31:0]);
    end
    neg_a = f_sgn && op_a[W-1];
    neg_b = f_sgn && op_b[W-1];
    mag_a = neg_a ? -op_a : op_a;
    mag_b = neg_b ? -op_b : op_b;

    // Bits are consumed from the MSB of opx, so a 32-bit operand is moved to the top.
    opx_init = f_div ? mag_a : mag_b;
    if (!f_d) opx_init = opx_init << SH32;
  end

  assign can_accept = start && (state == S_IDLE || state == S_DONE);
  assign go         = can_accept && is_md;
  assign busy       = (state == S_MUL) || (state == S_DIV) || (state == S_FIX);
  assign done       = (state == S_DONE);

  // ---------------- FSM ----------------
  // NOTE: sequential state uses non-blocking assignments. Every register then
  // updates from the values it had before the edge, whatever the process order.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      S_IDLE, S_DONE: state_nxt = go ? (f_div ? S_DIV : S_MUL) : S_IDLE;
      S_MUL, S_DIV:   if (cnt == 7'd1) state_nxt = S_FIX;
      S_FIX:          state_nxt = S_DONE;
      default:        state_nxt = S_IDLE;
    endcase
  end

  // ---------------- datapath ----------------
  logic [W:0]     div_shift, div_diff;
  logic [2*W-1:0] prod;
  logic [W-1:0]   quo, rmd, hi_n, lo_n;

  // A borrow into bit W means the trial subtraction went negative.
  // The remainder is always smaller than the divisor, so a true difference never reaches bit W.
  assign div_shift = {rem, opx[W-1]};
  assign div_diff  = div_shift - {1'b0, opy};

  always_comb begin
    prod = neg_q ? -acc : acc;
    // Divide by zero yields an all-ones quotient whatever the operand signs.
    quo  = (neg_q && !div_zero) ? -opx : opx;
    rmd  = neg_r ? -rem : rem;
    if (is_div) begin
      hi_n = rmd;
      lo_n = quo;
    end else if (is_d) begin
      hi_n = prod[2*W-1:W];
      lo_n = prod[W-1:0];
    end else begin
      hi_n = prod[63:32];
      lo_n = prod[31:0];
    end
    if (!is_d) begin
      hi_n = sext32(hi_n[31:0]);
      lo_n = sext32(lo_n[31:0]);
    end
  end

  // NOTE: the iteration registers are reset together with hi/lo. An aborted
  // operation then leaves nothing behind, and the registers never start from X in simulation.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      acc      <= '0;
      opx      <= '0;
      opy      <= '0;
      rem      <= '0;
      cnt      <= '0;
      is_d     <= 1'b0;
      is_div   <= 1'b0;
      neg_q    <= 1'b0;
      neg_r    <= 1'b0;
      div_zero <= 1'b0;
      hi       <= '0;
      lo       <= '0;
    end else begin
      unique case (state)
        S_IDLE, S_DONE: begin
          if (go) begin
            acc      <= '0;
            rem      <= '0;
            cnt      <= f_d ? 7'd64 : 7'd32;
            is_d     <= f_d;
            is_div   <= f_div;
            neg_q    <= neg_a ^ neg_b;
            neg_r    <= neg_a;
            div_zero <= (op_b == '0);
            opx      <= opx_init;
            opy      <= f_div ? mag_b : mag_a;
          end else if (can_accept && is_mthi) begin
            hi <= a;
          end else if (can_accept && is_mtlo) begin
            lo <= a;
          end
        end
        S_MUL: begin
          acc <= {acc[2*W-2:0], 1'b0} + (opx[W-1] ? {{W{1'b0}}, opy} : '0);
          opx <= {opx[W-2:0], 1'b0};
          cnt <= cnt - 7'd1;
        end
        S_DIV: begin
          if (!div_diff[W]) begin
            rem <= div_diff[W-1:0];
            opx <= {opx[W-2:0], 1'b1};
          end else begin
            rem <= div_shift[W-1:0];
            opx <= {opx[W-2:0], 1'b0};
          end
          cnt <= cnt - 7'd1;
        end
        S_FIX: begin
          hi <= hi_n;
          lo <= lo_n;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit: randomized and directed self-checking bench for muldiv_unit.
// A WIDTH=64 instance covers the full op set. A WIDTH=32 instance covers the narrow build.
// Expected hi/lo values come from an arithmetic model of the MIPS rules.
module tb_muldiv_unit;

  localparam logic [5:0] F_MULT   = 6'b011000, F_MULTU  = 6'b011001;
  localparam logic [5:0] F_DIV    = 6'b011010, F_DIVU   = 6'b011011;
  localparam logic [5:0] F_DMULT  = 6'b011100, F_DMULTU = 6'b011101;
  localparam logic [5:0] F_DDIV   = 6'b011110, F_DDIVU  = 6'b011111;
  localparam logic [5:0] F_MTHI   = 6'b010001, F_MTLO   = 6'b010011;

  logic        clk = 1'b0;
  logic        reset, start, start32;
  logic [5:0]  funct, funct32;
  logic [63:0] a, b, hi, lo;
  logic [31:0] a32, b32, hi32, lo32;
  logic        busy, done, busy32, done32;

  always #5 clk = ~clk;

  muldiv_unit #(.WIDTH(64)) dut (
    .clk(clk), .reset(reset), .start(start), .funct(funct), .a(a), .b(b),
    .busy(busy), .done(done), .hi(hi), .lo(lo)
  );

  muldiv_unit #(.WIDTH(32)) dut32 (
    .clk(clk), .reset(reset), .start(start32), .funct(funct32), .a(a32), .b(b32),
    .busy(busy32), .done(done32), .hi(hi32), .lo(lo32)
  );

  int          n_checks = 0;
  int          n_pass   = 0;
  int          seen;
  logic [63:0] exp_hi = '0;
  logic [63:0] exp_lo = '0;
  logic [5:0]  legal [10] = '{F_MULT, F_MULTU, F_DIV, F_DIVU, F_DMULT,
                              F_DMULTU, F_DDIV, F_DDIVU, F_MTHI, F_MTLO};

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  function automatic logic [63:0] sx32(input logic [31:0] x);
    return {{32{x[31]}}, x};
  endfunction

  // Reference: full-precision products and quotient/remainder from the signed rules.
  function automatic void model(input logic [5:0] f, input logic [63:0] av, input logic [63:0] bv,
                                output logic [63:0] eh, output logic [63:0] el);
    logic         d, sgn, dv, na, nb;
    logic [63:0]  ax, bx, ma, mb, q, r;
    logic [127:0] pa, pb, p;
    d   = f[2];
    sgn = ~f[0];
    dv  = f[1];
    ax  = d ? av : (sgn ? sx32(av[31:0]) : {32'h0, av[31:0]});
    bx  = d ? bv : (sgn ? sx32(bv[31:0]) : {32'h0, bv[31:0]});
    na  = sgn && ax[63];
    nb  = sgn && bx[63];
    if (!dv) begin
      pa = sgn ? {{64{ax[63]}}, ax} : {64'h0, ax};
      pb = sgn ? {{64{bx[63]}}, bx} : {64'h0, bx};
      p  = pa * pb;
      eh = d ? p[127:64] : sx32(p[63:32]);
      el = d ? p[63:0]   : sx32(p[31:0]);
    end else if (bx == 64'h0) begin
      el = '1;
      eh = d ? ax : sx32(ax[31:0]);
    end else begin
      ma = na ? -ax : ax;
      mb = nb ? -bx : bx;
      q  = ma / mb;
      r  = ma % mb;
      if (na ^ nb) q = -q;
      if (na)      r = -r;
      eh = d ? r : sx32(r[31:0]);
      el = d ? q : sx32(q[31:0]);
    end
  endfunction

  function automatic logic [63:0] pick();
    case ($urandom_range(0, 4))
      0:       return {$urandom, $urandom};
      1:       return 64'($urandom_range(0, 20));
      2:       return -64'($urandom_range(1, 20));
      3:       return {32'h0, $urandom};
      default: return $urandom_range(0, 1) ? 64'h8000_0000_0000_0000 : 64'hFFFF_FFFF_8000_0000;
    endcase
  endfunction

  // Issue a mul/div op and check latency, busy length, result and the single done pulse.
  // With disturb set, MTHI and DIVU requests are raised in the busy window and must be ignored.
  task automatic run_op(input logic [5:0] f, input logic [63:0] av, input logic [63:0] bv,
                        input bit disturb);
    int          lat, busy_cnt, n;
    logic [63:0] eh, el;
    model(f, av, bv, eh, el);
    n = f[2] ? 64 : 32;
    start = 1'b1; funct = f; a = av; b = bv;
    @(posedge clk); #1;
    start = 1'b0; funct = 6'($urandom); a = {$urandom, $urandom}; b = {$urandom, $urandom};
    lat = 0; busy_cnt = 0;
    while (!done && lat < 200) begin
      if (busy) busy_cnt++;
      start = 1'b0;
      if (disturb && lat == 3) begin start = 1'b1; funct = F_MTHI; end
      if (disturb && lat == 4) begin start = 1'b1; funct = F_DIVU; end
      @(posedge clk); #1;
      lat++;
    end
    start = 1'b0;
    check("latency", 64'(lat), 64'(n + 1));
    check("busy_cycles", 64'(busy_cnt), 64'(n + 1));
    check("busy_at_done", {63'h0, busy}, 64'h0);
    check("hi", hi, eh);
    check("lo", lo, el);
    exp_hi = eh;
    exp_lo = el;
    @(posedge clk); #1;
    check("done_single_pulse", {63'h0, done}, 64'h0);
  endtask

  task automatic mt_op(input logic [5:0] f, input logic [63:0] av);
    start = 1'b1; funct = f; a = av; b = {$urandom, $urandom};
    @(posedge clk); #1;
    start = 1'b0;
    if (f == F_MTHI) exp_hi = av;
    else             exp_lo = av;
    check("mt_busy", {63'h0, busy}, 64'h0);
    check("mt_hi", hi, exp_hi);
    check("mt_lo", lo, exp_lo);
    @(posedge clk); #1;
    check("mt_done", {63'h0, done}, 64'h0);
  endtask

  task automatic illegal_op(input logic [5:0] f);
    start = 1'b1; funct = f; a = {$urandom, $urandom}; b = {$urandom, $urandom};
    @(posedge clk); #1;
    start = 1'b0;
    check("illegal_busy", {63'h0, busy}, 64'h0);
    seen = 0;
    repeat (4) begin
      if (done) seen = 1;
      @(posedge clk); #1;
    end
    check("illegal_done", 64'(seen), 64'h0);
    check("illegal_hi", hi, exp_hi);
    check("illegal_lo", lo, exp_lo);
  endtask

  task automatic run32(input logic [5:0] f, input logic [31:0] av, input logic [31:0] bv);
    logic [63:0] eh, el;
    int          lat;
    model(f, {32'h0, av}, {32'h0, bv}, eh, el);
    start32 = 1'b1; funct32 = f; a32 = av; b32 = bv;
    @(posedge clk); #1;
    start32 = 1'b0;
    lat = 0;
    while (!done32 && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
    check("w32_latency", 64'(lat), 64'd33);
    check("w32_hi", {32'h0, hi32}, {32'h0, eh[31:0]});
    check("w32_lo", {32'h0, lo32}, {32'h0, el[31:0]});
    @(posedge clk); #1;
  endtask

  initial begin
    reset = 1'b0; start = 1'b0; funct = '0; a = '0; b = '0;
    start32 = 1'b0; funct32 = '0; a32 = '0; b32 = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_busy", {63'h0, busy}, 64'h0);
    check("rst_done", {63'h0, done}, 64'h0);
    check("rst_hi", hi, 64'h0);
    check("rst_lo", lo, 64'h0);
    reset = 1'b1;
    @(posedge clk); #1;

    // Directed cases: sign handling, D-ops, divide by zero, MIN / -1.
    run_op(F_MULT,  64'h0000_0000_FFFF_FFFE, 64'd3, 1'b0);
    run_op(F_DDIVU, 64'd100, 64'd7, 1'b0);
    run_op(F_DDIV,  64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 1'b0);
    run_op(F_DIV,   64'd5, 64'd0, 1'b0);
    run_op(F_DIV,   64'h0000_0000_8000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0);
    run_op(F_DDIV,  64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0);
    run_op(F_MULTU, 64'h0000_0000_DEAD_BEEF, 64'h0000_0000_1234_5678, 1'b1);

    // Reset in the middle of a DMULT aborts at once and produces no done.
    start = 1'b1; funct = F_DMULT; a = 64'h1234_5678_9ABC_DEF0; b = 64'h0FED_CBA9_8765_4321;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    reset = 1'b0;
    #1;
    check("abort_busy", {63'h0, busy}, 64'h0);
    check("abort_hi", hi, 64'h0);
    check("abort_lo", lo, 64'h0);
    exp_hi = '0;
    exp_lo = '0;
    @(negedge clk);
    reset = 1'b1;
    seen = 0;
    repeat (80) begin
      @(posedge clk); #1;
      if (done) seen = 1;
    end
    check("abort_no_done", 64'(seen), 64'h0);
    run_op(F_MULT, 64'hFFFF_FFFF_FFFF_FFF9, 64'h0000_0000_7FFF_FFFF, 1'b0);

    illegal_op(6'b101100);
    mt_op(F_MTHI, 64'hA5A5_5A5A_0F0F_F0F0);
    mt_op(F_MTLO, 64'h0123_4567_89AB_CDEF);

    // Randomized traffic across every legal funct.
    for (int i = 0; i < 40; i++) begin
      logic [5:0] f;
      f = legal[$urandom_range(0, 9)];
      if (f == F_MTHI || f == F_MTLO) mt_op(f, pick());
      else                            run_op(f, pick(), pick(), 1'b0);
    end

    // WIDTH=32 build: D-ops are illegal, 32-bit ops behave as usual.
    start32 = 1'b1; funct32 = F_DMULT; a32 = 32'd6; b32 = 32'd7;
    @(posedge clk); #1;
    start32 = 1'b0;
    check("w32_dmult_busy", {63'h0, busy32}, 64'h0);
    seen = 0;
    repeat (4) begin
      if (done32) seen = 1;
      @(posedge clk); #1;
    end
    check("w32_dmult_done", 64'(seen), 64'h0);
    run32(F_MULT, 32'hFFFF_FFFE, 32'd3);
    run32(F_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
    for (int i = 0; i < 6; i++)
      run32(legal[$urandom_range(0, 3)], $urandom, 32'($urandom_range(0, 1000)));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
